// File: rtl/score_counter.sv
// score_counter
// -------------
// One cascadable decimal score digit with a seven-segment display output.
// The digit counts up or down by one on requests from game logic or from a
// less-significant digit, and emits carry/borrow pulses to the next
// more-significant digit. Carry and borrow are combinational so that a
// whole chain of digits updates on the same clock edge.
//
// Optional build macro: SCORE_COUNTER_EDGE_EN
//   defined     - requests are edge-detected. A level held for N cycles
//                 counts exactly once.
//   not defined - requests are level-sensitive. The digit steps once per
//                 clock while a request is high.
//
// Parameters:
//   MAX_COUNT   highest digit value (1..15). Counting up wraps MAX_COUNT->0.
//   BLANK_ZERO  when 1, the display blanks at count 0 unless otherLeds=1.
//
// Ports:
//   clk              in   rising-edge clock
//   Reset            in   asynchronous active-low reset
//   incrementInPos   in   count-up request
//   incrementInNeg   in   count-down request
//   otherLeds        in   a more-significant digit is non-zero
//   incrementOutPos  out  carry pulse to the next digit
//   incrementOutNeg  out  borrow pulse to the next digit
//   leds[6:0]        out  active-low segments, bit order {g,f,e,d,c,b,a}
//   count[3:0]       out  registered digit value
//
// Handshake: there is no valid/ready pair. Each request is sampled on every
// rising clk edge while Reset=1. A carry or borrow output is valid in the
// same cycle as the request that causes it, and the receiving digit consumes
// it on that same edge.
module score_counter #(
  parameter int unsigned MAX_COUNT  = 9,
  parameter bit          BLANK_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       incrementInPos,
  input  logic       incrementInNeg,
  input  logic       otherLeds,
  output logic       incrementOutPos,
  output logic       incrementOutNeg,
  output logic [6:0] leds,
  output logic [3:0] count
);

  localparam logic [3:0] MAX_C = 4'(MAX_COUNT);

  logic [3:0] count_q, count_d;
  logic       pos_req, neg_req;
  logic       up, dn;
  logic       at_max, at_zero;

`ifdef SCORE_COUNTER_EDGE_EN
  logic pos_prev_q, pos_prev_d;
  logic neg_prev_q, neg_prev_d;

  always_comb begin
    pos_prev_d = incrementInPos;
    neg_prev_d = incrementInNeg;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pos_prev_q <= 1'b0;
      neg_prev_q <= 1'b0;
    end else begin
      pos_prev_q <= pos_prev_d;
      neg_prev_q <= neg_prev_d;
    end
  end

  // Only a 0->1 transition forms a request. Carry and borrow inherit this
  // edge qualification through up/dn.
  assign pos_req = incrementInPos & ~pos_prev_q;
  assign neg_req = incrementInNeg & ~neg_prev_q;
`else
  assign pos_req = incrementInPos;
  assign neg_req = incrementInNeg;
`endif

  // Simultaneous up and down requests cancel.
  assign up      = pos_req & ~neg_req;
  assign dn      = neg_req & ~pos_req;
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == 4'd0);

  always_comb begin
    count_d = count_q;
    if (up) begin
      count_d = at_max ? 4'd0 : count_q + 4'd1;
    end else if (dn) begin
      if (!at_zero) begin
        count_d = count_q - 4'd1;
      end else if (otherLeds) begin
        count_d = MAX_C;
      end
      // At zero with no higher digits the score floors at 0.
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count           = count_q;
  assign incrementOutPos = up & at_max;
  assign incrementOutNeg = dn & at_zero & otherLeds;

  // Seven-segment decode, active-low {g,f,e,d,c,b,a}.
  logic [6:0] seg;
  always_comb begin
    seg = 7'b1111111;
    case (count_q)
      4'd0:  seg = 7'b1000000;
      4'd1:  seg = 7'b1111001;
      4'd2:  seg = 7'b0100100;
      4'd3:  seg = 7'b0110000;
      4'd4:  seg = 7'b0011001;
      4'd5:  seg = 7'b0010010;
      4'd6:  seg = 7'b0000010;
      4'd7:  seg = 7'b1111000;
      4'd8:  seg = 7'b0000000;
      4'd9:  seg = 7'b0010000;
      4'd10: seg = 7'b0001000; // A
      4'd11: seg = 7'b0000011; // b
      4'd12: seg = 7'b1000110; // C
      4'd13: seg = 7'b0100001; // d
      4'd14: seg = 7'b0000110; // E
      4'd15: seg = 7'b0001110; // F
      default: seg = 7'b1111111;
    endcase
  end

  always_comb begin
    leds = seg;
    // A leading zero goes dark when no more-significant digit is lit.
    if (BLANK_ZERO && at_zero && !otherLeds) begin
      leds = 7'b1111111;
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Testbench for score_counter. Two instances share all inputs:
//   dut0: MAX_COUNT=9,  BLANK_ZERO=0 (decimal digit)
//   dut1: MAX_COUNT=12, BLANK_ZERO=1 (exercises hex glyphs and blanking)
// A reference model tracks each digit as an integer and applies the
// counting rules arithmetically.
module tb_score_counter;

  logic       clk;
  logic       Reset;
  logic       inc_pos, inc_neg, other_leds;
  logic       out_pos0, out_neg0, out_pos1, out_neg1;
  logic [6:0] leds0, leds1;
  logic [3:0] count0, count1;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int  m_c0, m_c1;
  bit  m_ppos, m_pneg;
  logic [6:0] seg_tab [16];

  score_counter #(.MAX_COUNT(9), .BLANK_ZERO(1'b0)) dut0 (
    .clk(clk), .Reset(Reset),
    .incrementInPos(inc_pos), .incrementInNeg(inc_neg), .otherLeds(other_leds),
    .incrementOutPos(out_pos0), .incrementOutNeg(out_neg0),
    .leds(leds0), .count(count0)
  );

  score_counter #(.MAX_COUNT(12), .BLANK_ZERO(1'b1)) dut1 (
    .clk(clk), .Reset(Reset),
    .incrementInPos(inc_pos), .incrementInNeg(inc_neg), .otherLeds(other_leds),
    .incrementOutPos(out_pos1), .incrementOutNeg(out_neg1),
    .leds(leds1), .count(count1)
  );

  // Clock and reset-level driving.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int c, input int mx, input bit up, input bit dn, input bit oth);
    if (up) return (c == mx) ? 0 : c + 1;
    if (dn) begin
      if (c > 0) return c - 1;
      return oth ? mx : 0;
    end
    return c;
  endfunction

  function automatic logic [6:0] exp_leds(input int c, input bit blank, input bit oth);
    if (blank && c == 0 && !oth) return 7'b1111111;
    return seg_tab[c];
  endfunction

  // One clock of stimulus: drive at negedge, check combinational outputs
  // against the model, then advance the model at the rising edge.
  task automatic step(input bit p, input bit n, input bit o);
    bit pe, ne, up, dn;
    @(negedge clk);
    inc_pos = p; inc_neg = n; other_leds = o;
    #1;
`ifdef SCORE_COUNTER_EDGE_EN
    pe = p & ~m_ppos;
    ne = n & ~m_pneg;
`else
    pe = p;
    ne = n;
`endif
    up = pe & ~ne;
    dn = ne & ~pe;
    check("count0", {4'd0, count0}, 8'(m_c0));
    check("count1", {4'd0, count1}, 8'(m_c1));
    check("leds0",  {1'b0, leds0}, {1'b0, exp_leds(m_c0, 1'b0, o)});
    check("leds1",  {1'b0, leds1}, {1'b0, exp_leds(m_c1, 1'b1, o)});
    check("carry0", {7'd0, out_pos0}, {7'd0, up && m_c0 == 9});
    check("borrow0",{7'd0, out_neg0}, {7'd0, dn && m_c0 == 0 && o});
    check("carry1", {7'd0, out_pos1}, {7'd0, up && m_c1 == 12});
    check("borrow1",{7'd0, out_neg1}, {7'd0, dn && m_c1 == 0 && o});
    @(posedge clk);
    m_c0 = nxt(m_c0, 9, up, dn, o);
    m_c1 = nxt(m_c1, 12, up, dn, o);
    m_ppos = p;
    m_pneg = n;
    #1;
  endtask

  // Reset asserted between clock edges must clear the count immediately.
  task automatic async_reset(input bit o);
    @(negedge clk);
    inc_pos = 1'b0; inc_neg = 1'b0; other_leds = o;
    #2;
    Reset = 1'b0;
    #1;
    check("rst_count0", {4'd0, count0}, 8'd0);
    check("rst_count1", {4'd0, count1}, 8'd0);
    check("rst_leds0",  {1'b0, leds0}, {1'b0, 7'b1000000});
    check("rst_leds1",  {1'b0, leds1}, {1'b0, exp_leds(0, 1'b1, o)});
    m_c0 = 0; m_c1 = 0; m_ppos = 1'b0; m_pneg = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    m_c0 = 0; m_c1 = 0; m_ppos = 1'b0; m_pneg = 1'b0;

    // Power-on reset, inputs idle.
    Reset = 1'b0; inc_pos = 1'b0; inc_neg = 1'b0; other_leds = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    check("por_count0", {4'd0, count0}, 8'd0);
    check("por_leds0",  {1'b0, leds0}, {1'b0, 7'b1000000});
    check("por_leds1",  {1'b0, leds1}, {1'b0, 7'b1111111});
    check("por_carry0", {7'd0, out_pos0}, 8'd0);
    check("por_borrow0",{7'd0, out_neg0}, 8'd0);

    // Hold count-up for 10 clocks, then idle one cycle to observe.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Floor at zero and borrow from zero.
    async_reset(1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Both requests together (dut0 should be at its max here).
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Count to 5 with pulses, then reset between edges.
    async_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    async_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    async_reset(1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Randomized walk, biased toward single requests.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 9 && i % 50 == 7) begin
        async_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- One cascadable decimal score digit with seven-segment output, for the game scoreboards.
- Counts up or down by one on pulses from game logic or from a less-significant digit.
- Emits carry and borrow pulses to the next more-significant digit.
- Optional leading-zero blanking uses a flag from the more-significant digits.

Parameters:
- MAX_COUNT, 9, highest digit value; the count wraps MAX_COUNT→0 going up; legal range 1..15.
- BLANK_ZERO, 0, when 1 the display blanks at count 0 unless otherLeds=1.

Ports:
- clk  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset; Reset=0 forces the reset state immediately.
- incrementInPos  input  1  count-up request.
- incrementInNeg  input  1  count-down request.
- otherLeds  input  1  high when any more-significant digit is non-zero.
- incrementOutPos  output  1  carry pulse to the next digit.
- incrementOutNeg  output  1  borrow pulse to the next digit.
- leds  output  7  seven-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
- count  output  4  current digit value, registered.

Behaviour:
- Reset (Reset=0, asynchronous):
  - count=0.
  - Edge-detect history registers (when present) cleared to 0.
  - Outputs follow from count=0 and the current inputs; no output is forced separately.
- Request decode, per rising clk edge with Reset=1:
  - up = incrementInPos & ~incrementInNeg.
  - dn = incrementInNeg & ~incrementInPos.
  - Both requests high, or both low: count holds; no carry, no borrow.
- Count up (up=1):
  - count<MAX_COUNT → count+1.
  - count==MAX_COUNT → count=0.
- Count down (dn=1):
  - count>0 → count-1.
  - count==0 and otherLeds=1 → count=MAX_COUNT.
  - count==0 and otherLeds=0 → count holds at 0 (score floor); no borrow.
- Carry/borrow outputs are combinational, so a whole cascade updates on the same clock edge:
  - incrementOutPos = up & (count==MAX_COUNT).
  - incrementOutNeg = dn & (count==0) & otherLeds.
- Rate: a request held high counts once per clock; it is not edge-detected unless the optional feature is enabled.
- Display (leds), combinational from count:
  - 0..9 use the standard active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10..15 show hex A..F.
  - BLANK_ZERO=1 and count==0 and otherLeds=0 → leds=1111111.
- Count never exceeds MAX_COUNT.
- Reset asserted mid-count overrides any request on the same edge.

Optional Feature:
- Macro SCORE_COUNTER_EDGE_EN.
- Defined:
  - incrementInPos and incrementInNeg are each registered.
  - Only rising edges (current=1, previous=0) form the up/dn requests, so a level held N cycles counts exactly once.
  - Carry and borrow are qualified by the same edge term.
- Not defined: level-sensitive, one step per clock while a request is high.

Test Plan:
- Reset=0 for 5 clocks, then Reset=1, inputs idle → count=0, leds=1000000, incrementOutPos=0, incrementOutNeg=0.
- incrementInPos=1 held 10 clocks (no macro) → count 1,2,…,9,0; incrementOutPos=1 only in the cycle with count=9; leds track each digit.
- With SCORE_COUNTER_EDGE_EN, incrementInPos held 10 clocks → count=1 only; incrementOutPos stays 0.
- From count=0:
  - incrementInNeg=1 with otherLeds=0 → count stays 0, incrementOutNeg=0.
  - With otherLeds=1 → count=9, incrementOutNeg=1 for that cycle.
- incrementInPos=1 and incrementInNeg=1 together at count=9 → count stays 9, no carry, no borrow.
- Count to 5, drive Reset=0 between clock edges → count=0 and leds=1000000 immediately, before the next clk edge. With BLANK_ZERO=1 and otherLeds=0 → leds=1111111.
